// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types and constants for the game controller and win checker.
package tictactoe_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned NUM_CELLS = 9;
  localparam logic [ADDR_W-1:0] NULL_ADDR = 4'b1111;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  typedef enum logic [1:0] {
    NOWIN = 2'b00,
    TIE   = 2'b01,
    P2    = 2'b10,
    P1    = 2'b11
  } winnerType;

  // Game controller state encoding.
  typedef enum logic [2:0] {
    CTRL_IDLE,
    CTRL_P1_MOVE,
    CTRL_P2_MOVE,
    CTRL_WAIT_CHECK,
    CTRL_GAME_OVER
  } statetype;

  // Win checker state encoding.
  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } checkStateType;

  // The eight winning lines, row-major cell indices; scan order is array order.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/line_match.sv
// Combinational test of one board line: all three cells equal and occupied.
module line_match
  import tictactoe_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       match,
  output logic [1:0] code
);

  // Report the shared cell code when the line is owned by one player.
  always_comb begin
    match = (a != EMPTY) && (a == b) && (b == c);
    code  = match ? a : NOWIN;
  end

endmodule

// File: rtl/win_checker.sv
// Shadows the board from the controller write bus and scans one winning line
// per cycle after each accepted move.
// Optional macro WIN_CHECKER_LINE_OUT_EN adds the win_line output.
module win_checker #(
  parameter int unsigned       ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] NULL_ADDR = 4'b1111,
  parameter int unsigned       NUM_CELLS = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              new_game,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        cellState,
  output logic              gameIsDone,
  output logic [1:0]        winner,
  output logic              busy,
  output logic              illegal_move
`ifdef WIN_CHECKER_LINE_OUT_EN
  ,
  output logic [2:0]        win_line
`endif
);

  import tictactoe_pkg::*;

  checkStateType state, state_nxt;
  logic [1:0]    cells [NUM_CELLS];
  logic [3:0]    move_cnt;
  logic [2:0]    idx;
  logic          wr_attempt;
  logic          accept;
  logic          full;
  logic          last_line;
  logic [1:0]    la, lb, lc;
  logic          lm_match;
  logic [1:0]    lm_code;

  // Decode the write attempt and whether it may land on the board.
  always_comb begin
    wr_attempt = (addr != NULL_ADDR);
    accept     = 1'b0;
    if (state == IDLE && wr_attempt && addr < ADDR_W'(NUM_CELLS) && cellState != EMPTY)
      accept = (cells[addr] == EMPTY);
    full      = (move_cnt == 4'd9);
    last_line = (idx == 3'd7);
  end

  // Select the three cells of the line currently under test.
  always_comb begin
    la = cells[WIN_LINES[idx][0]];
    lb = cells[WIN_LINES[idx][1]];
    lc = cells[WIN_LINES[idx][2]];
  end

  line_match u_line_match (
    .a     (la),
    .b     (lb),
    .c     (lc),
    .match (lm_match),
    .code  (lm_code)
  );

  // Next-state logic; new_game returns to IDLE regardless of activity.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SCAN;
      SCAN: begin
        if (lm_match)       state_nxt = DONE;
        else if (last_line) state_nxt = full ? DONE : IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (new_game) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Board shadow, move count, scan index and registered results.
  always_ff @(posedge clk) begin
    if (!reset_n || new_game) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) cells[i] <= '0;
      move_cnt     <= '0;
      idx          <= '0;
      winner       <= NOWIN;
      gameIsDone   <= 1'b0;
      busy         <= 1'b0;
      illegal_move <= 1'b0;
`ifdef WIN_CHECKER_LINE_OUT_EN
      win_line     <= '0;
`endif
    end else begin
      illegal_move <= wr_attempt && !accept;
      if (accept) begin
        cells[addr] <= cellState;
        move_cnt    <= move_cnt + 4'd1;
        idx         <= '0;
        busy        <= 1'b1;
      end
      if (state == SCAN) begin
        if (lm_match) begin
          winner     <= lm_code;
          gameIsDone <= 1'b1;
          busy       <= 1'b0;
`ifdef WIN_CHECKER_LINE_OUT_EN
          win_line   <= idx;
`endif
        end else if (last_line) begin
          busy <= 1'b0;
          if (full) begin
            winner     <= TIE;
            gameIsDone <= 1'b1;
          end
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/win_checker.md
Name: win_checker

Overview:
- Sits directly downstream of the game controller and snoops its board-write bus (addr, cellState).
- Keeps a shadow copy of the 3x3 board and, after each accepted move, scans the 8 winning lines sequentially, one line per cycle.
- Drives gameIsDone and winner back to the controller, closing the move loop.
- Also flags illegal moves: occupied cell or bad address.

Parameters:
- ADDR_W, 4, width of the cell address bus.
- NULL_ADDR, 4'b1111, address meaning "no write this cycle".
- NUM_CELLS, 9, board cells; addresses 0..8 are valid, row-major (0 = top-left).

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- new_game  in  1  synchronous board clear, one-cycle pulse.
- addr  in  ADDR_W  cell address from the controller; NULL_ADDR = idle.
- cellState  in  2  cell code to write: EMPTY 00, O 11, X 10.
- gameIsDone  out  1  game finished (win or tie); held until reset or new_game.
- winner  out  2  player1/O 11, player2/X 10, tie 01, noWin 00.
- busy  out  1  high while a scan is in progress.
- illegal_move  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (reset_n=0 at an edge):
  - All 9 cells, move count, line index, winner, gameIsDone, busy and illegal_move go to 0.
  - FSM goes to IDLE.
  - Reset has priority over every other input, including mid-scan.
- new_game=1: same clearing effect as reset; any write in the same cycle is dropped.
- Write attempt: addr != NULL_ADDR in any cycle.
- Accepted write requires all of:
  - FSM in IDLE.
  - addr <= 8.
  - cellState != EMPTY.
  - Target cell currently EMPTY.
- On an accepted write:
  - cell[addr] <= cellState; move count increments (4-bit, max 9).
  - FSM goes to SCAN with line index 0.
  - busy=1 from the next cycle.
- Rejected write (fails any condition above, including arriving in SCAN or DONE): board unchanged; illegal_move=1 for exactly the next cycle.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: waits for an accepted write.
  - SCAN: evaluates line[idx] per cycle.
    - Line order: 0:(0,1,2) 1:(3,4,5) 2:(6,7,8) 3:(0,3,6) 4:(1,4,7) 5:(2,5,8) 6:(0,4,8) 7:(2,4,6).
    - Match = all three cells equal and non-EMPTY.
    - On the first match: winner <= the matching cell code (11 or 10), gameIsDone <= 1, go to DONE. Early exit; remaining lines are not scanned.
    - After idx 7 with no match and move count == 9: winner <= 01, gameIsDone <= 1, go to DONE.
    - After idx 7 with no match and move count < 9: back to IDLE, busy <= 0.
  - DONE: absorbing until reset or new_game; busy=0; every write is rejected.
- Latency: for an accepted write at edge N, the board updates at N, line 0 is checked in cycle N+1, and the result is registered at edge N+1+k for a match on line k.
  - Worst case: gameIsDone visible after edge N+8.
  - A non-winning, non-final move returns to IDLE at edge N+8.
- winner holds 00 whenever gameIsDone=0.
- Simultaneous events:
  - new_game and a write in the same cycle: new_game wins.
  - Reset mid-SCAN: the scan is aborted and nothing is reported.

Optional Feature:
- Macro: WIN_CHECKER_LINE_OUT_EN.
- Defined:
  - Adds output win_line [2:0], the index of the matching line; it is registered together with gameIsDone and valid only when winner is 11 or 10.
  - It is 0 on reset, new_game or tie. Used by the display to highlight the winning line.
- Undefined: port absent; no other behaviour change.

Decomposition:
- Shared package tictactoe_pkg:
  - cellStateType (EMPTY/O/X).
  - winnerType (NOWIN 00, TIE 01, P2 10, P1 11).
  - NULL_ADDR.
  - Constant WIN_LINES[8][3] of 4-bit cell indices.
- The statetype of the game controller also moves into tictactoe_pkg.
- Sub-module line_match: combinational; takes three 2-bit cells and outputs match plus the matching code. Instantiated once and fed by a mux indexed by the line counter.

Test Plan:
- O writes cells 0, 1, 2 in IDLE gaps, X writes 3 and 4 → after the write to cell 2, gameIsDone=1 and winner=11 on the edge after line 0 is checked (1 cycle after the board update).
- X writes cells 2, 4, 6 (O elsewhere, no O line) → win detected on line 7, latency 8 edges, winner=10 (plus win_line=7 with WIN_CHECKER_LINE_OUT_EN).
- Full board with no line (O: 0,2,3,7,8; X: 1,4,5,6) → after the 9th move, winner=01 and gameIsDone=1.
- Write to an occupied cell 4, then to addr 12, then a write while busy=1 → illegal_move pulses 3 times, board and move count unchanged.
- new_game in DONE → winner=00, gameIsDone=0, board empty; next write to 0 is accepted.
- reset_n=0 asserted during SCAN cycle 3 → all outputs 0 on the next edge, no result reported afterwards.
